// File: rtl/draw_text_box.sv
// Text-box overlay for a pipelined VGA bus: addresses an external character/font
// path, then paints glyph, background and blink onto the delayed pixel stream.
module draw_text_box #(
  parameter logic [11:0] TEXT_COLOUR  = 12'h0_2_9,
  parameter logic [11:0] BG_COLOUR    = 12'h0_0_0,
  parameter int          TEXT_POS_X   = 50,
  parameter int          TEXT_POS_Y   = 50,
  parameter int          TEXT_SIZE_X  = 16,
  parameter int          TEXT_SIZE_Y  = 16,
  parameter int          SCALE_LOG2   = 0,
  parameter int          BLINK_FRAMES = 30,
  parameter int          VGA_BUS_SIZE = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    text_en,
  input  logic                    bg_en,
  input  logic                    blink_en,
  input  logic [7:0]              char_pixels,
  input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic [7:0]              char_xy,
  output logic [3:0]              char_line
);

  localparam logic [10:0] POS_X = 11'(TEXT_POS_X);
  localparam logic [10:0] POS_Y = 11'(TEXT_POS_Y);
  localparam logic [12:0] X_LO  = 13'(TEXT_POS_X);
  localparam logic [12:0] X_HI  = 13'(TEXT_POS_X + ((8 * TEXT_SIZE_X) << SCALE_LOG2));
  localparam logic [12:0] Y_LO  = 13'(TEXT_POS_Y);
  localparam logic [12:0] Y_HI  = 13'(TEXT_POS_Y + ((16 * TEXT_SIZE_Y) << SCALE_LOG2));
  localparam logic [7:0]  LAST_FRAME = 8'(BLINK_FRAMES - 1);

  typedef enum logic {BLINK_OFF = 1'b0, BLINK_ON = 1'b1} blinkState_t;

  logic [VGA_BUS_SIZE-1:0] busD1_q, busD2_q, busOut_q;
  logic [7:0]  charXy_q;
  logic [3:0]  charLine_q;
  blinkState_t blinkState_q;
  logic [7:0]  frameCnt_q;
  logic        vsync_q;

  logic [10:0] hcountIn, vcountIn, offH, offV;
  logic [3:0]  colIdx, rowIdx, lineIdx;
  logic        vsyncIn;
  logic [10:0] hcountD2, vcountD2, offHD2;
  logic [2:0]  bitSel;
  logic [11:0] rgbD2, rgbOut_d;
  logic        inBox, pixelBit, visible;

  assign hcountIn = vga_bus_in[VGA_BUS_SIZE-1 -: 11];
  assign vcountIn = vga_bus_in[23:13];
  assign vsyncIn  = vga_bus_in[12];

  // Offsets wrap modularly; left/above the box they produce junk addresses
  // that the box test below keeps away from the pixel output.
  assign offH    = hcountIn - POS_X;
  assign offV    = vcountIn - POS_Y;
  assign colIdx  = 4'((offH >> SCALE_LOG2) >> 3);
  assign rowIdx  = 4'((offV >> SCALE_LOG2) >> 4);
  assign lineIdx = 4'(offV >> SCALE_LOG2);

  assign hcountD2 = busD2_q[VGA_BUS_SIZE-1 -: 11];
  assign vcountD2 = busD2_q[23:13];
  assign rgbD2    = busD2_q[11:0];
  assign offHD2   = hcountD2 - POS_X;
  assign bitSel   = 3'(offHD2 >> SCALE_LOG2);
  assign pixelBit = char_pixels[~bitSel];
  assign visible  = ~blink_en | (blinkState_q == BLINK_ON);

  assign inBox = ({2'b00, hcountD2} >= X_LO) && ({2'b00, hcountD2} < X_HI) &&
                 ({2'b00, vcountD2} >= Y_LO) && ({2'b00, vcountD2} < Y_HI);

  // A hidden glyph pixel falls back to the background rule, not to pass-through.
  always_comb begin
    rgbOut_d = rgbD2;
    if (text_en && inBox) begin
      if (pixelBit && visible) rgbOut_d = TEXT_COLOUR;
      else if (bg_en)          rgbOut_d = BG_COLOUR;
    end
  end

  // Addressing stage plus the two-deep delay line that waits for char_pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      charXy_q   <= '0;
      charLine_q <= '0;
      busD1_q    <= '0;
      busD2_q    <= '0;
      busOut_q   <= '0;
    end else begin
      charXy_q   <= {colIdx, rowIdx};
      charLine_q <= lineIdx;
      busD1_q    <= vga_bus_in;
      busD2_q    <= busD1_q;
      busOut_q   <= {busD2_q[VGA_BUS_SIZE-1:12], rgbOut_d};
    end
  end

  // Blink runs free of text_en/blink_en so the phase stays frame-locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blinkState_q <= BLINK_ON;
      frameCnt_q   <= '0;
      vsync_q      <= 1'b0;
    end else begin
      vsync_q <= vsyncIn;
      if (vsyncIn && !vsync_q) begin
        if (frameCnt_q == LAST_FRAME) begin
          frameCnt_q   <= '0;
          blinkState_q <= (blinkState_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
          frameCnt_q <= frameCnt_q + 8'd1;
        end
      end
    end
  end

  assign vga_bus_out = busOut_q;
  assign char_xy     = charXy_q;
  assign char_line   = charLine_q;

endmodule

// File: tb/tb_draw_text_box.sv
// Bench for draw_text_box: directed vector table, multi-cycle latency/blink
// sequences, and a randomized run against a per-sample reference model.
module tb_draw_text_box;

  localparam logic [11:0] TEXT_C = 12'h029;
  localparam logic [11:0] BG_C   = 12'h000;
  localparam int          N_RAND = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        textEn, bgEn, blinkEn;
  logic        romMode;
  logic [7:0]  romConst;
  logic [35:0] busIn;
  logic [35:0] busOut0, busOut1;
  logic [7:0]  xy0, xy1, pix0, pix1;
  logic [3:0]  line0, line1;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    string       name;
    logic [10:0] h;
    logic [10:0] v;
    logic [11:0] rgb;
    logic        ten;
    logic        ben;
    logic [7:0]  pix;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  logic [35:0] smp[N_RAND];
  logic [2:0]  ctl[N_RAND];
  int          edges[N_RAND+1];

  // dut0: unscaled with a short blink period; dut1: 2x scale, default blink.
  draw_text_box #(.BLINK_FRAMES(2)) dut0 (
    .clk(clk), .rst(rst), .text_en(textEn), .bg_en(bgEn), .blink_en(blinkEn),
    .char_pixels(pix0), .vga_bus_in(busIn), .vga_bus_out(busOut0),
    .char_xy(xy0), .char_line(line0)
  );

  draw_text_box #(.SCALE_LOG2(1)) dut1 (
    .clk(clk), .rst(rst), .text_en(textEn), .bg_en(bgEn), .blink_en(blinkEn),
    .char_pixels(pix1), .vga_bus_in(busIn), .vga_bus_out(busOut1),
    .char_xy(xy1), .char_line(line1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [7:0] xy, input logic [3:0] ln);
    logic [7:0] r;
    r = 8'(int'(xy) * 29 + int'(ln) * 113 + 60);
    return r ^ {ln, xy[3:0]};
  endfunction

  // Font/character source with one register of latency, as the overlay expects.
  always @(posedge clk) begin
    pix0 <= romMode ? romConst : glyph(xy0, line0);
    pix1 <= romMode ? romConst : glyph(xy1, line1);
  end

  function automatic logic [7:0] modelXy(input int s, input logic [10:0] h, input logic [10:0] v);
    int oh, ov;
    oh = ((int'(h) - 50) & 2047) >> s;
    ov = ((int'(v) - 50) & 2047) >> s;
    return 8'(((oh / 8) % 16) * 16 + (ov / 16) % 16);
  endfunction

  function automatic logic [3:0] modelLine(input int s, input logic [10:0] v);
    int ov;
    ov = ((int'(v) - 50) & 2047) >> s;
    return 4'(ov % 16);
  endfunction

  function automatic logic [11:0] modelRgb(input int s, input logic [10:0] h, input logic [10:0] v,
                                           input logic [11:0] rgb, input logic ten, input logic ben,
                                           input logic blen, input logic phase);
    int oh, ov;
    logic [7:0] px;
    logic bitv;
    if (!ten || h < 50 || int'(h) >= 50 + (128 << s) || v < 50 || int'(v) >= 50 + (256 << s))
      return rgb;
    oh = (int'(h) - 50) >> s;
    ov = (int'(v) - 50) >> s;
    px = glyph(8'((oh / 8) * 16 + ov / 16), 4'(ov % 16));
    bitv = px[7 - (oh % 8)];
    if (bitv && (!blen || phase)) return TEXT_C;
    if (ben) return BG_C;
    return rgb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                               input logic [11:0] rgb, input logic vs);
    busIn = {h, 1'b0, v, vs, rgb};
  endtask

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    busIn = 36'h5_A5A5_A5A5;
    tick();
    tick();
    checkOutput("reset_bus0", busOut0, 36'h0);
    checkOutput("reset_bus1", busOut1, 36'h0);
    checkOutput("reset_xy_line", {28'h0, xy0}, {32'h0, line0});
    rst = 1'b0;
    busIn = '0;
  endtask

  task automatic vsyncPulse(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
    applyStimulus(h, v, rgb, 1'b1);
    tick(); tick();
    applyStimulus(h, v, rgb, 1'b0);
    tick(); tick();
  endtask

  task automatic checkBlink(input string name, input logic [11:0] exp);
    repeat (4) tick();
    checkOutput(name, {24'h0, busOut0[11:0]}, {24'h0, exp});
  endtask

  initial begin
    logic vsLast;
    logic [10:0] h, v;
    logic [11:0] rgb;
    logic [35:0] s, expBus;
    logic ph0, ph1;

    vecs[0]  = '{"passthru",    11'd100, 11'd60,  12'hABC, 1'b0, 1'b0, 8'hFF, 12'hABC};
    vecs[1]  = '{"glyph_50",    11'd50,  11'd50,  12'h555, 1'b1, 1'b0, 8'h80, TEXT_C};
    vecs[2]  = '{"glyph_51",    11'd51,  11'd50,  12'h555, 1'b1, 1'b0, 8'h80, 12'h555};
    vecs[3]  = '{"right_edge",  11'd178, 11'd60,  12'h777, 1'b1, 1'b1, 8'hFF, 12'h777};
    vecs[4]  = '{"left_edge",   11'd49,  11'd60,  12'h777, 1'b1, 1'b1, 8'hFF, 12'h777};
    vecs[5]  = '{"last_col_bg", 11'd177, 11'd60,  12'h777, 1'b1, 1'b1, 8'h00, BG_C};
    vecs[6]  = '{"last_col_fg", 11'd177, 11'd60,  12'h777, 1'b1, 1'b0, 8'h01, TEXT_C};
    vecs[7]  = '{"bottom_in",   11'd60,  11'd305, 12'h123, 1'b1, 1'b0, 8'hFF, TEXT_C};
    vecs[8]  = '{"bottom_out",  11'd60,  11'd306, 12'h123, 1'b1, 1'b0, 8'hFF, 12'h123};
    vecs[9]  = '{"top_out",     11'd60,  11'd49,  12'h123, 1'b1, 1'b1, 8'hFF, 12'h123};
    vecs[10] = '{"bit0",        11'd57,  11'd50,  12'h456, 1'b1, 1'b1, 8'h01, TEXT_C};
    vecs[11] = '{"next_char",   11'd58,  11'd50,  12'h456, 1'b1, 1'b1, 8'h01, BG_C};

    textEn = 1'b0; bgEn = 1'b0; blinkEn = 1'b0;
    romMode = 1'b1; romConst = 8'h80;
    resetDut();

    // Exact 3-cycle latency, zero outputs before it, and addressing timing.
    applyStimulus(11'd100, 11'd60, 12'hABC, 1'b0);
    tick();
    checkOutput("lat_c0", busOut0, 36'h0);
    applyStimulus(11'd50, 11'd50, 12'h555, 1'b0);
    tick();
    checkOutput("lat_c1", busOut0, 36'h0);
    checkOutput("xy0_50_50", {28'h0, xy0}, 36'h0);
    checkOutput("line0_50_50", {32'h0, line0}, 36'h0);
    applyStimulus(11'd66, 11'd83, 12'h111, 1'b0);
    tick();
    checkOutput("lat_c2", busOut0, {11'd100, 1'b0, 11'd60, 1'b0, 12'hABC});
    checkOutput("xy1_66_83", {28'h0, xy1}, {28'h0, modelXy(1, 11'd66, 11'd83)});
    checkOutput("line1_66_83", {32'h0, line1}, {32'h0, modelLine(1, 11'd83)});

    for (int i = 0; i < 12; i++) begin
      textEn = vecs[i].ten; bgEn = vecs[i].ben; romConst = vecs[i].pix;
      applyStimulus(vecs[i].h, vecs[i].v, vecs[i].rgb, 1'b0);
      repeat (4) tick();
      checkOutput(vecs[i].name, {24'h0, busOut0[11:0]}, {24'h0, vecs[i].exp});
    end

    // Scaled columns: 50 and 51 share bit 7 at 2x, 52 moves to bit 6.
    textEn = 1'b1; bgEn = 1'b1; romConst = 8'h80;
    applyStimulus(11'd51, 11'd50, 12'hEEE, 1'b0);
    repeat (4) tick();
    checkOutput("scale_51_dut1", {24'h0, busOut1[11:0]}, {24'h0, TEXT_C});
    checkOutput("scale_51_dut0", {24'h0, busOut0[11:0]}, {24'h0, BG_C});
    applyStimulus(11'd52, 11'd50, 12'hEEE, 1'b0);
    repeat (4) tick();
    checkOutput("scale_52_dut1", {24'h0, busOut1[11:0]}, {24'h0, BG_C});

    // Blink on dut0 (2 frames per half-period), including reset mid-blink.
    textEn = 1'b1; bgEn = 1'b0; blinkEn = 1'b1; romConst = 8'hFF;
    resetDut();
    applyStimulus(11'd60, 11'd60, 12'hF0F, 1'b0);
    checkBlink("blink_f0", TEXT_C);
    vsyncPulse(11'd60, 11'd60, 12'hF0F); checkBlink("blink_f1", TEXT_C);
    vsyncPulse(11'd60, 11'd60, 12'hF0F); checkBlink("blink_f2", 12'hF0F);
    vsyncPulse(11'd60, 11'd60, 12'hF0F); checkBlink("blink_f3", 12'hF0F);
    vsyncPulse(11'd60, 11'd60, 12'hF0F); checkBlink("blink_f4", TEXT_C);
    vsyncPulse(11'd60, 11'd60, 12'hF0F); checkBlink("blink_f5", TEXT_C);
    blinkEn = 1'b0; checkBlink("blink_disabled", TEXT_C);
    blinkEn = 1'b1;
    resetDut();
    applyStimulus(11'd60, 11'd60, 12'hF0F, 1'b0);
    repeat (3) vsyncPulse(11'd60, 11'd60, 12'hF0F);
    checkBlink("blink_f3_again", 12'hF0F);
    resetDut();
    applyStimulus(11'd60, 11'd60, 12'hF0F, 1'b0);
    checkBlink("blink_after_rst", TEXT_C);
    vsyncPulse(11'd60, 11'd60, 12'hF0F); checkBlink("blink_rst_f1", TEXT_C);
    vsyncPulse(11'd60, 11'd60, 12'hF0F); checkBlink("blink_rst_f2", 12'hF0F);

    // Randomized run: each sample predicted independently from its own fields.
    romMode = 1'b0;
    resetDut();
    vsLast = 1'b0;
    edges[0] = 0;
    for (int t = 0; t < N_RAND; t++) begin
      h = 11'($urandom_range(40, 320));
      v = 11'($urandom_range(40, 580));
      rgb = 12'($urandom);
      if ($urandom_range(0, 5) == 0) vsLast = ~vsLast;
      s = {h, 1'($urandom), v, vsLast, rgb};
      smp[t] = s;
      edges[t+1] = edges[t] + ((t == 0) ? int'(vsLast) : int'(vsLast && !smp[t-1][12]));
      ctl[t] = 3'($urandom);
      {textEn, bgEn, blinkEn} = ctl[t];
      busIn = s;
      tick();
      checkOutput("rand_xy0", {28'h0, xy0}, {28'h0, modelXy(0, h, v)});
      checkOutput("rand_xy1", {28'h0, xy1}, {28'h0, modelXy(1, h, v)});
      checkOutput("rand_line0", {32'h0, line0}, {32'h0, modelLine(0, v)});
      if (t < 2) begin
        checkOutput("rand_early0", busOut0, 36'h0);
        checkOutput("rand_early1", busOut1, 36'h0);
      end else begin
        s = smp[t-2];
        ph0 = ((edges[t] / 2) % 2) == 0;
        ph1 = ((edges[t] / 30) % 2) == 0;
        expBus = {s[35:12], modelRgb(0, s[35:25], s[23:13], s[11:0], ctl[t][2], ctl[t][1], ctl[t][0], ph0)};
        checkOutput("rand_out0", busOut0, expBus);
        expBus = {s[35:12], modelRgb(1, s[35:25], s[23:13], s[11:0], ctl[t][2], ctl[t][1], ctl[t][0], ph1)};
        checkOutput("rand_out1", busOut1, expBus);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
